// File: rtl/ibuf_refill_ctrl.sv
// Instruction-buffer refill sequencer: hit detection, window rebase and burst refill from memory.
// Latency: a hit in IDLE gives ins_valid one cycle later; a refill takes BURST request/response rounds.
// Backpressure: stall holds fetch during any refill; mem_req is held until mem_gnt, one request outstanding.
module ibuf_refill_ctrl #(
    parameter int DEPTH = 128,
    parameter int BURST = 12,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_pc,
    input  logic             redirect,
    output logic             stall,
    output logic             ins_valid,
    output logic [IDX_W-1:0] buf_ridx,
    output logic [31:0]      base_out,
    output logic             buf_we,
    output logic [IDX_W-1:0] buf_waddr,
    output logic [31:0]      buf_wdata,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             fault
);

    // One extra bit so the counters can hold the value BURST == DEPTH.
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t          state;
    logic [31:0]     base;
    logic [CW-1:0]   fill_cnt;
    logic [CW-1:0]   issue_cnt;

    logic            aligned;
    logic [29:0]     off_w;
    logic            hit;
    logic [CW-1:0]   cnt_nxt;
    logic            burst_done;

    // base is only ever captured from an aligned pc, so its low bits are zero
    // and the word offset is the difference of the word addresses.
    assign aligned    = (fetch_pc[1:0] == 2'b00);
    assign off_w      = fetch_pc[31:2] - base[31:2];
    assign hit        = aligned && (fetch_pc >= base) &&
                        (off_w < {{(30-CW){1'b0}}, fill_cnt});
    assign cnt_nxt    = issue_cnt + 1'b1;
    assign burst_done = (cnt_nxt == CW'(BURST));

    assign stall      = (state != IDLE) || (fetch_req && aligned && !hit);
    assign buf_ridx   = off_w[IDX_W-1:0];
    assign base_out   = base;

    assign mem_req    = (state == REQ);
    assign mem_addr   = base + {{(30-CW){1'b0}}, issue_cnt, 2'b00};

    // Write straight through so a word is in the buffer before IDLE can hit on it.
    assign buf_we     = (state == WAIT) && mem_rvalid;
    assign buf_waddr  = issue_cnt[IDX_W-1:0];
    assign buf_wdata  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= 32'h0;
            fill_cnt  <= '0;
            issue_cnt <= '0;
            ins_valid <= 1'b0;
            fault     <= 1'b0;
        end else begin
            ins_valid <= (state == IDLE) && fetch_req && hit;
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        if (!aligned) begin
                            fault <= 1'b1;
                        end else begin
                            fault <= 1'b0;
                            if (!hit && !redirect) begin
                                state     <= REQ;
                                base      <= fetch_pc;
                                fill_cnt  <= '0;
                                issue_cnt <= '0;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt)
                        state <= redirect ? DRAIN : WAIT;
                    else if (redirect)
                        state <= IDLE;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        fill_cnt  <= cnt_nxt;
                        issue_cnt <= cnt_nxt;
                        state     <= (burst_done || redirect) ? IDLE : REQ;
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The granted read still returns; swallow it without writing.
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibuf_refill_ctrl.sv
// Directed bench for ibuf_refill_ctrl: burst refill, hits, misses, fault, redirect aborts and reset.
module tb_ibuf_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic        stall;
    logic        ins_valid;
    logic [6:0]  buf_ridx;
    logic [31:0] base_out;
    logic        buf_we;
    logic [6:0]  buf_waddr;
    logic [31:0] buf_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ibuf_refill_ctrl #(.DEPTH(128), .BURST(12), .IDX_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .redirect(redirect),
        .stall(stall), .ins_valid(ins_valid), .buf_ridx(buf_ridx), .base_out(base_out),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fault(fault)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Entered one step after an edge with the DUT in REQ; serves words [first, first+n).
    task automatic serve_words(input logic [31:0] wbase, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            chk_val("mem_req", {31'b0, mem_req}, 32'd1);
            chk_val("mem_addr", mem_addr, wbase + 32'(4 * i));
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            chk_val("req_after_gnt", {31'b0, mem_req}, 32'd0);
            tick();
            mem_rvalid = 1'b1;
            mem_rdata  = pat(i);
            #1;
            chk_val("buf_we", {31'b0, buf_we}, 32'd1);
            chk_val("buf_waddr", {25'b0, buf_waddr}, 32'(i));
            chk_val("buf_wdata", buf_wdata, pat(i));
            tick();
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        #1;
        chk_val("miss_stall", {31'b0, stall}, 32'd1);
        tick();
        chk_val("rebase", base_out, pc);
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = 32'h0; redirect = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        chk_val("rst_stall", {31'b0, stall}, 32'd0);
        chk_val("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        chk_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk_val("rst_buf_we", {31'b0, buf_we}, 32'd0);
        chk_val("rst_fault", {31'b0, fault}, 32'd0);
        chk_val("rst_base", base_out, 32'h0);
        rst_n = 1'b1;
        tick();

        // Full burst at 0x100
        start_fetch(32'h100);
        serve_words(32'h100, 0, 12);
        chk_val("fill_done_base", base_out, 32'h100);
        chk_val("fill_done_stall", {31'b0, stall}, 32'd0);

        fetch_pc = 32'h108;
        #1;
        chk_val("hit_stall", {31'b0, stall}, 32'd0);
        chk_val("hit_ridx", {25'b0, buf_ridx}, 32'd2);
        tick();
        chk_val("hit_ins_valid", {31'b0, ins_valid}, 32'd1);

        // Index 12 is past the window
        start_fetch(32'h130);
        chk_val("miss_ins_valid", {31'b0, ins_valid}, 32'd0);
        serve_words(32'h130, 0, 12);

        // Below base
        start_fetch(32'h0FC);
        serve_words(32'h0FC, 0, 12);

        // Misaligned fetch
        fetch_pc = 32'h102;
        #1;
        chk_val("misal_stall", {31'b0, stall}, 32'd0);
        tick();
        chk_val("misal_fault", {31'b0, fault}, 32'd1);
        chk_val("misal_no_req", {31'b0, mem_req}, 32'd0);
        fetch_req = 1'b0;
        tick();
        chk_val("fault_sticky", {31'b0, fault}, 32'd1);

        // Redirect in REQ without grant
        start_fetch(32'h200);
        chk_val("fault_cleared", {31'b0, fault}, 32'd0);
        redirect = 1'b1;
        #1;
        chk_val("redir_req_hold", {31'b0, mem_req}, 32'd1);
        tick();
        redirect = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk_val("redir_req_drop", {31'b0, mem_req}, 32'd0);
        chk_val("redir_idle_stall", {31'b0, stall}, 32'd0);

        // Redirect in WAIT after 5 words
        start_fetch(32'h100);
        serve_words(32'h100, 0, 5);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk_val("drain_stall", {31'b0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk_val("drain_no_we", {31'b0, buf_we}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        fetch_pc = 32'h110;
        #1;
        chk_val("partial_hit_stall", {31'b0, stall}, 32'd0);
        chk_val("partial_hit_ridx", {25'b0, buf_ridx}, 32'd4);
        tick();
        chk_val("partial_hit_valid", {31'b0, ins_valid}, 32'd1);

        // Index 5 was never written; redirect arrives with the grant
        start_fetch(32'h114);
        mem_gnt = 1'b1;
        redirect = 1'b1;
        tick();
        mem_gnt = 1'b0;
        redirect = 1'b0;
        chk_val("gnt_redir_no_req", {31'b0, mem_req}, 32'd0);
        chk_val("gnt_redir_stall", {31'b0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b1;
        #1;
        chk_val("gnt_redir_no_we", {31'b0, buf_we}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk_val("gnt_redir_idle", {31'b0, stall}, 32'd0);

        // Reset in the middle of a burst
        start_fetch(32'h300);
        serve_words(32'h300, 0, 3);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        fetch_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_val("arst_mem_req", {31'b0, mem_req}, 32'd0);
        chk_val("arst_stall", {31'b0, stall}, 32'd0);
        chk_val("arst_base", base_out, 32'h0);
        chk_val("arst_ins_valid", {31'b0, ins_valid}, 32'd0);
        chk_val("arst_fault", {31'b0, fault}, 32'd0);
        rst_n = 1'b1;
        tick();
        start_fetch(32'h100);
        chk_val("post_rst_addr", mem_addr, 32'h100);
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        fetch_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
